// File: rtl/seg7_scan_capture.sv
// Purpose : capture a scanned 4-digit 7-segment bus, debounce each digit, decode glyphs to hex, assemble 16-bit frames.
// Latency : input edge to capture STABLE_CNT+1 cycles; fourth capture to o_frame_valid 1 cycle.
// Backpressure: none; the scanning source cannot be stalled, partial frames are dropped after TIMEOUT cycles.
//
// Ports:
//   i_clk, i_rst        clock and asynchronous active-high reset
//   i_dig_en[3:0]       one-hot digit enable (bit i = digit i)
//   i_seg[6:0]          segments {a,b,c,d,e,f,g}, active high
//   o_value[15:0]       last completed frame, digit i in [4i+3:4i]
//   o_frame_valid       one-cycle pulse when o_value updates
//   o_glyph_err         1 if any digit of the last frame was undecodable; held until next frame
//   o_frame_timeout     one-cycle pulse when a partial frame is dropped
//   o_digit_mask[3:0]   digits captured so far in the current frame
module seg7_scan_capture #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_dig_en,
  input  logic [6:0]  i_seg,
  output logic [15:0] o_value,
  output logic        o_frame_valid,
  output logic        o_glyph_err,
  output logic        o_frame_timeout,
  output logic [3:0]  o_digit_mask
);

  // Stability counter must be able to hold STABLE_CNT itself (saturation value).
  localparam int SCW = $clog2(STABLE_CNT + 1);
  localparam int TOW = $clog2(TIMEOUT);
  localparam logic [SCW-1:0] SC_MAX  = SCW'(STABLE_CNT);
  localparam logic [SCW-1:0] SC_ARM  = SCW'(STABLE_CNT - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Input stage and the one-cycle-older copy used for the stability compare
  logic [3:0]     r_dig_en;
  logic [6:0]     r_seg;
  logic [3:0]     r_prev_dig_en;
  logic [6:0]     r_prev_seg;
  logic [SCW-1:0] r_stab_cnt;

  // Frame assembly
  state_t         r_state;
  logic [TOW-1:0] r_tmo_cnt;
  logic [3:0]     r_mask;
  logic [3:0]     r_bad;
  logic [15:0]    r_slots;
  logic [15:0]    r_value;
  logic           r_glyph_err;
  logic           r_frame_valid;
  logic           r_frame_timeout;

  logic           w_onehot;
  logic           w_same;
  logic [SCW-1:0] w_stab_nxt;
  logic           w_capture;
  logic [3:0]     w_nib;
  logic           w_bad;
  state_t         w_state_nxt;
  logic [TOW-1:0] w_tmo_nxt;
  logic           w_emit;
  logic           w_drop;
  logic [3:0]     w_mask_nxt;
  logic [3:0]     w_bad_nxt;

  assign w_onehot = (r_dig_en != 4'd0) && ((r_dig_en & (r_dig_en - 4'd1)) == 4'd0);
  assign w_same   = (r_dig_en == r_prev_dig_en) && (r_seg == r_prev_seg);

  always_comb begin
    w_stab_nxt = r_stab_cnt;
    if (!w_onehot) begin
      w_stab_nxt = '0;
    end else if (w_same) begin
      if (r_stab_cnt != SC_MAX) begin
        w_stab_nxt = r_stab_cnt + SCW'(1);
      end
    end else begin
      w_stab_nxt = SCW'(1);
    end
  end

  // Fires only on the step into SC_MAX; saturation then blocks re-capture until the pair changes.
  assign w_capture = w_onehot && w_same && (r_stab_cnt == SC_ARM);

  always_comb begin
    w_nib = 4'h0;
    w_bad = 1'b0;
    case (r_seg)
      7'h7E: w_nib = 4'h0;
      7'h30: w_nib = 4'h1;
      7'h6D: w_nib = 4'h2;
      7'h79: w_nib = 4'h3;
      7'h33: w_nib = 4'h4;
      7'h5B: w_nib = 4'h5;
      7'h5F: w_nib = 4'h6;
      7'h70: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h7B: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h1F: w_nib = 4'hB;
      7'h4E: w_nib = 4'hC;
      7'h3D: w_nib = 4'hD;
      7'h4F: w_nib = 4'hE;
      7'h47: w_nib = 4'hF;
      default: begin
        w_nib = 4'h0;
        w_bad = 1'b1;
      end
    endcase
  end

  // Next-state: completion is checked before timeout so it wins a tie.
  // A capture coinciding with emit/drop opens the next frame immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo_cnt;
    w_emit      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_nxt = ST_COLLECT;
          w_tmo_nxt   = '0;
        end
      end
      ST_COLLECT: begin
        if (r_mask == 4'hF) begin
          w_emit      = 1'b1;
          w_state_nxt = w_capture ? ST_COLLECT : ST_IDLE;
          w_tmo_nxt   = '0;
        end else if (r_tmo_cnt == TO_LAST) begin
          w_drop      = 1'b1;
          w_state_nxt = w_capture ? ST_COLLECT : ST_IDLE;
          w_tmo_nxt   = '0;
        end else begin
          w_tmo_nxt   = r_tmo_cnt + TOW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmo_nxt   = '0;
      end
    endcase
  end

  // Mask and bad bits clear on frame end, then the same-cycle capture (if any) is applied on top.
  always_comb begin
    w_mask_nxt = (w_emit || w_drop) ? 4'h0 : r_mask;
    w_bad_nxt  = (w_emit || w_drop) ? 4'h0 : r_bad;
    if (w_capture) begin
      w_mask_nxt = w_mask_nxt | r_dig_en;
      w_bad_nxt  = (w_bad_nxt & ~r_dig_en) | (w_bad ? r_dig_en : 4'h0);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dig_en        <= 4'h0;
      r_seg           <= 7'h00;
      r_prev_dig_en   <= 4'h0;
      r_prev_seg      <= 7'h00;
      r_stab_cnt      <= '0;
      r_state         <= ST_IDLE;
      r_tmo_cnt       <= '0;
      r_mask          <= 4'h0;
      r_bad           <= 4'h0;
      r_slots         <= 16'h0000;
      r_value         <= 16'h0000;
      r_glyph_err     <= 1'b0;
      r_frame_valid   <= 1'b0;
      r_frame_timeout <= 1'b0;
    end else begin
      r_dig_en        <= i_dig_en;
      r_seg           <= i_seg;
      r_prev_dig_en   <= r_dig_en;
      r_prev_seg      <= r_seg;
      r_stab_cnt      <= w_stab_nxt;
      r_state         <= w_state_nxt;
      r_tmo_cnt       <= w_tmo_nxt;
      r_mask          <= w_mask_nxt;
      r_bad           <= w_bad_nxt;
      r_frame_valid   <= w_emit;
      r_frame_timeout <= w_drop;
      for (int i = 0; i < 4; i++) begin
        if (w_capture && r_dig_en[i]) begin
          r_slots[4*i +: 4] <= w_nib;
        end
      end
      if (w_emit) begin
        r_value     <= r_slots;
        r_glyph_err <= |r_bad;
      end
    end
  end

  assign o_value         = r_value;
  assign o_frame_valid   = r_frame_valid;
  assign o_glyph_err     = r_glyph_err;
  assign o_frame_timeout = r_frame_timeout;
  assign o_digit_mask    = r_mask;

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

  logic        clk;
  logic        rst;
  logic [3:0]  dig_en;
  logic [6:0]  seg;
  logic [15:0] value;
  logic        frame_valid;
  logic        glyph_err;
  logic        frame_timeout;
  logic [3:0]  digit_mask;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int to_cnt = 0;
  int first_cap_cyc = -2;
  int fv_base;
  int to_base;
  logic seen;

  seg7_scan_capture #(.STABLE_CNT(4), .TIMEOUT(64)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_dig_en       (dig_en),
    .i_seg          (seg),
    .o_value        (value),
    .o_frame_valid  (frame_valid),
    .o_glyph_err    (glyph_err),
    .o_frame_timeout(frame_timeout),
    .o_digit_mask   (digit_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (frame_valid === 1'b1) fv_cnt++;
    if (frame_timeout === 1'b1) to_cnt++;
    if (first_cap_cyc == -1 && digit_mask != 4'h0) first_cap_cyc = cyc;
  endtask

  task automatic drive(input int d, input logic [6:0] s, input int n);
    dig_en = 4'(4'b0001 << d);
    seg    = s;
    repeat (n) tick();
  endtask

  task automatic idle(input int n);
    dig_en = 4'h0;
    seg    = 7'h00;
    repeat (n) tick();
  endtask

  initial begin
    rst    = 1'b1;
    dig_en = 4'h0;
    seg    = 7'h00;
    repeat (3) tick();
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_glyph_err", 32'(glyph_err), 32'h0);
    chk("rst_frame_timeout", 32'(frame_timeout), 32'h0);
    chk("rst_digit_mask", 32'(digit_mask), 32'h0);
    rst = 1'b0;
    idle(3);

    // Clean scan F,2,A,1
    fv_base = fv_cnt;
    drive(0, 7'h47, 8);
    chk("t1_mask_after_d0", 32'(digit_mask), 32'h1);
    drive(1, 7'h6D, 8);
    drive(2, 7'h77, 8);
    chk("t1_mask_after_d2", 32'(digit_mask), 32'h7);
    drive(3, 7'h30, 8);
    idle(4);
    chk("t1_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    chk("t1_value", 32'(value), 32'h1A2F);
    chk("t1_glyph_err", 32'(glyph_err), 32'h0);
    chk("t1_mask_cleared", 32'(digit_mask), 32'h0);

    // Bad glyph on digit 2, then a clean frame clears the error
    fv_base = fv_cnt;
    drive(0, 7'h47, 8);
    drive(1, 7'h6D, 8);
    drive(2, 7'h01, 8);
    drive(3, 7'h30, 8);
    idle(4);
    chk("t2_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    chk("t2_value", 32'(value), 32'h102F);
    chk("t2_glyph_err", 32'(glyph_err), 32'h1);
    idle(6);
    chk("t2_glyph_err_held", 32'(glyph_err), 32'h1);
    drive(0, 7'h47, 8);
    drive(1, 7'h6D, 8);
    drive(2, 7'h77, 8);
    drive(3, 7'h30, 8);
    idle(4);
    chk("t2_clean_glyph_err", 32'(glyph_err), 32'h0);
    chk("t2_clean_value", 32'(value), 32'h1A2F);

    // Dwell filter: 7E for 2, then 30; capture exactly on the 5th tick after the change
    fv_base = fv_cnt;
    drive(0, 7'h7E, 2);
    drive(0, 7'h30, 3);
    chk("t3_no_cap_3", 32'(digit_mask), 32'h0);
    tick();
    chk("t3_no_cap_4", 32'(digit_mask), 32'h0);
    tick();
    chk("t3_cap_5", 32'(digit_mask), 32'h1);
    repeat (15) tick();
    chk("t3_mask_held", 32'(digit_mask), 32'h1);
    drive(1, 7'h33, 8);
    drive(2, 7'h5B, 8);
    drive(3, 7'h5F, 8);
    idle(4);
    chk("t3_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    chk("t3_value", 32'(value), 32'h6541);

    // Partial frame timeout
    fv_base = fv_cnt;
    to_base = to_cnt;
    first_cap_cyc = -1;
    drive(0, 7'h7E, 8);
    drive(1, 7'h30, 8);
    chk("t4_mask_partial", 32'(digit_mask), 32'h3);
    dig_en = 4'h0;
    seg    = 7'h00;
    seen   = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (frame_timeout === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t4_timeout_seen", 32'(seen), 32'h1);
    chk("t4_timeout_delay", 32'(cyc - first_cap_cyc), 32'd64);
    chk("t4_mask_cleared", 32'(digit_mask), 32'h0);
    tick();
    chk("t4_timeout_pulse", 32'(frame_timeout), 32'h0);
    chk("t4_timeout_count", 32'(to_cnt - to_base), 32'd1);
    chk("t4_value_kept", 32'(value), 32'h6541);
    chk("t4_glyph_err_kept", 32'(glyph_err), 32'h0);
    chk("t4_no_fv", 32'(fv_cnt - fv_base), 32'd0);
    first_cap_cyc = -2;

    // Reset mid-frame discards the partial frame
    drive(0, 7'h7F, 8);
    drive(1, 7'h7B, 8);
    drive(2, 7'h4E, 8);
    chk("t5_mask_pre_rst", 32'(digit_mask), 32'h7);
    rst    = 1'b1;
    dig_en = 4'h0;
    seg    = 7'h00;
    tick();
    rst = 1'b0;
    chk("t5_rst_mask", 32'(digit_mask), 32'h0);
    chk("t5_rst_value", 32'(value), 32'h0);
    fv_base = fv_cnt;
    drive(0, 7'h4F, 8);
    idle(2);
    chk("t5_single_mask", 32'(digit_mask), 32'h1);
    chk("t5_single_no_fv", 32'(fv_cnt - fv_base), 32'd0);
    drive(0, 7'h4F, 8);
    drive(1, 7'h47, 8);
    drive(2, 7'h4E, 8);
    drive(3, 7'h3D, 8);
    idle(4);
    chk("t5_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    chk("t5_value", 32'(value), 32'hDCFE);
    chk("t5_glyph_err", 32'(glyph_err), 32'h0);

    // Multi-hot enable never captures
    fv_base = fv_cnt;
    dig_en = 4'b0011;
    seg    = 7'h7F;
    repeat (20) tick();
    chk("t6_mask", 32'(digit_mask), 32'h0);
    chk("t6_no_fv", 32'(fv_cnt - fv_base), 32'd0);
    chk("t6_value", 32'(value), 32'hDCFE);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive side of the multiplexed 7-segment display interface. It samples a 4-digit scanned display bus (digit enable plus segment lines), filters glitches, and decodes each stable segment glyph back to a 4-bit hex code.
- It assembles a 16-bit frame once all four digits have been captured, then reports a per-frame glyph error and a frame timeout.
- Used as a display-loopback checker and for capturing display contents from a scanning driver.

Parameters:
- STABLE_CNT, 4, consecutive identical samples required before a digit is captured (minimum 2).
- TIMEOUT, 1024, cycles allowed from first capture of a frame to frame completion before the partial frame is dropped.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- dig_en  input  4  active-high digit enable, one-hot when valid; bit i selects digit i.
- seg  input  7  active-high segments, seg[6:0] = {a,b,c,d,e,f,g}.
- value  output  16  last completed frame; digit i in value[4i+3:4i].
- frame_valid  output  1  one-cycle pulse when value updates.
- glyph_err  output  1  valid with frame_valid and held until the next frame: 1 if any digit of the frame had an undecodable glyph.
- frame_timeout  output  1  one-cycle pulse when a partial frame is dropped.
- digit_mask  output  4  digits captured so far in the current frame.

Behaviour:
- Reset: value=0, frame_valid=0, glyph_err=0, frame_timeout=0, digit_mask=0.
  - Also cleared: input registers, stability counter, slots, bad bits, timeout counter; state=IDLE.
  - Any frame in progress when rst asserts is discarded.
- Input stage: dig_en and seg are registered once (1 cycle), with no metastability synchronizer.
- Stability filter on the registered pair:
  - If dig_en is not one-hot (0000 or multi-hot), the counter is cleared and no capture occurs.
  - Else, if the pair equals the previous registered pair, the counter increments, saturating at STABLE_CNT. Otherwise the counter is set to 1.
  - A capture fires on the single cycle the counter reaches STABLE_CNT. There is exactly one capture per dwell; a re-capture needs a change and a new dwell.
- Glyph decode (exact match, hex):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70.
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
  - Any other pattern is invalid: the nibble is stored as 0 and the digit's bad bit is set.
- On capture of digit i:
  - The slot i nibble and bad bit i are written, and digit_mask[i] is set.
  - If the digit is already in the mask, the latest capture overwrites the slot and bad bit; this is not an error.
- FSM, states IDLE and COLLECT:
  - IDLE -> COLLECT on the first capture. The timeout counter loads 0.
  - In COLLECT, the timeout counter increments every cycle.
  - COLLECT -> IDLE when digit_mask becomes 1111. On the next cycle:
    - value is loaded from the slots, glyph_err = OR of the bad bits, and frame_valid pulses.
    - digit_mask and the bad bits clear.
  - COLLECT -> IDLE when the timeout counter reaches TIMEOUT-1 without a full mask. On the next cycle:
    - frame_timeout pulses and digit_mask clears.
    - value and glyph_err are unchanged.
  - Completion and timeout in the same cycle: completion wins and there is no timeout pulse.
  - A capture in the same cycle as frame emission starts a new frame: that digit's mask bit is set after the clear, and state=COLLECT.
- Latency:
  - Input edge to capture is STABLE_CNT+1 cycles for a dwell starting from a different pair.
  - Fourth capture to frame_valid is 1 cycle.
- Counters are sized by $clog2 of their parameter, and none of them wrap.

Test Plan:
- Scan digits 0..3 with seg 47, 6D, 77, 30, 8 cycles each, STABLE_CNT=4 -> frame_valid pulses once, value=16'h1A2F, glyph_err=0, digit_mask returns to 0.
- Same scan with dig2 seg=7'h01 -> value=16'h102F, glyph_err=1; the next clean frame clears glyph_err.
- dig0 with seg=7E for 2 cycles, then 30 for 3 cycles, then 30 held -> no capture until the 4th consecutive 30; slot0=1; exactly one capture per dwell.
- Capture digits 0 and 1, then hold dig_en=0000 with TIMEOUT=64 -> frame_timeout pulses after 64 cycles from the first capture, digit_mask=0, value unchanged, no frame_valid.
- Capture 3 digits, assert rst for 1 cycle, then scan 1 digit -> no frame_valid; after a full 4-digit scan, value reflects only post-reset data.
- Hold dig_en=0011 with seg=7F for 20 cycles -> no capture, digit_mask stays 0.
